pending_encoder_32: RTL and testbench
=====================================

// Module: pending_encoder_32
// PURPOSE
//  Sequential 32:5 encoder, the inverse of the 5:32 write-select decoder.
//  Accepts a multi-hot 32-bit request vector, such as pending register writebacks or exception causes.
//  Emits the index of each set bit as a 5-bit code, one per handshake, lowest index first.
//  Sits between the hazard/exception collection logic and the serialised consumer in the pipeline.
// PARAMETERS
//  WIDTH     32               request vector width; power of two, >= 2
//  IDX_W     $clog2(WIDTH)    index width (5 at default)
//  LSB_FIRST 1                1: serve lowest set bit first; 0: highest first
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  reset      in   1      asynchronous, active-low reset
//  flush      in   1      synchronous abort; discards pending bits
//  load_valid in   1      load_vec is valid
//  load_ready out  1      block can accept load_vec this cycle
//  load_vec   in   WIDTH  multi-hot request vector
//  out_valid  out  1      out_idx is valid
//  out_ready  in   1      consumer accepts out_idx this cycle
//  out_idx    out  IDX_W  encoded index of the current selected bit
//  out_last   out  1      current index is the final pending bit
//  busy       out  1      state == DRAIN
// BEHAVIOUR
//  Reset (reset==0, async): pending=0, state=IDLE.
//   Outputs during reset: out_valid=0, out_idx=0, out_last=0, busy=0, load_ready=1.
//  States: IDLE, DRAIN. The pending register is WIDTH bits.
//  IDLE:
//   - load_ready = !flush.
//   - Load accepted when load_valid && load_ready.
//   - Accepted load_vec != 0: pending <= load_vec, go to DRAIN.
//   - Accepted load_vec == 0: dropped, stay IDLE, no output.
//  DRAIN:
//   - out_valid = 1.
//   - out_idx = encode(pending): lowest set bit, or highest if LSB_FIRST==0.
//   - out_last = ((pending & (pending-1)) == 0).
//   - Latency: load accepted at edge N -> out_valid=1 from cycle N+1.
//   - Transfer when out_valid && out_ready: selected bit of pending is cleared; next index appears the following cycle.
//   - Transfer with out_last: go to IDLE.
//   - Back-to-back: load_ready = !flush && out_ready && out_last.
//     A load accepted in the same cycle as the last transfer loads pending and stays in DRAIN (no bubble).
//   - out_valid held, out_idx/out_last stable while out_ready==0.
//  flush==1 (any state): pending <= 0, state <= IDLE, load_ready=0.
//   Flush wins over a same-cycle load or transfer.
//  out_idx = 0 and out_last = 0 whenever out_valid == 0.
//  Reset asserted mid-DRAIN: immediate return to reset values; no partial output.
//  Index width: out_idx is zero-extended encoding; WIDTH-1 max value (31 at default).
// STRUCTURE
//  Shared package pending_enc_pkg:
//   - state_t enum {IDLE, DRAIN}
//   - PENC_WIDTH = 32
//   - PENC_IDX_W = 5
//  Sub-module prio_enc_comb (purely combinational, parameterised WIDTH/LSB_FIRST):
//   - in:  vec[WIDTH-1:0]
//   - out: idx[IDX_W-1:0], any
//   - Instantiated once on pending.
//  Remaining RTL: state register, pending register, clear-mask (1<<idx), handshake logic.
// TESTING
//  1. Reset state: hold reset=0 -> out_valid=0, busy=0, load_ready=1.
//     Release reset, no load -> outputs stay at reset values.
//  2. Multi-bit drain: load_vec=32'h8000_0025, out_ready=1 -> out_idx 0, 2, 5, 31 on consecutive cycles.
//     out_last=1 only with 31; IDLE the next cycle.
//  3. Backpressure: load_vec=32'h0000_0300, out_ready=0 for 3 cycles -> out_idx=8 held stable.
//     Then out_ready=1 -> 8, then 9 with out_last=1.
//  4. Back-to-back: during the last transfer of 32'h1, present load_vec=32'h4 -> load_ready=1, no idle cycle.
//     Next cycle out_idx=2, out_last=1.
//  5. Flush and zero load: flush mid-drain of 32'hFFFF_FFFF with load_valid=1 -> next cycle IDLE, out_valid=0, load not taken.
//     Load of 32'h0 -> stays IDLE, no out_valid.
//  6. LSB_FIRST=0 instance: load_vec=32'h8000_0025 -> out_idx 31, 5, 2, 0.
//     Async reset asserted mid-drain clears outputs without a clock edge.

Source files
------------

// File: rtl/pending_encoder_32_pkg.sv
// Shared types and sizing for the pending-bit encoder.
package pending_enc_pkg;
  localparam int PENC_WIDTH = 32;
  localparam int PENC_IDX_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/pending_encoder_32_prio_enc_comb.sv
// Combinational priority encoder: index of the lowest (or highest) set bit.
module prio_enc_comb #(
  parameter int WIDTH     = 32,
  parameter int LSB_FIRST = 1,
  parameter int IDX_W     = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  assign any = |vec;

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      // Scan downward so the lowest set bit is the last assignment.
      always_comb begin
        idx = '0;
        for (int i = WIDTH-1; i >= 0; i--)
          if (vec[i]) idx = IDX_W'(i);
      end
    end else begin : g_msb
      always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
          if (vec[i]) idx = IDX_W'(i);
      end
    end
  endgenerate
endmodule

// File: rtl/pending_encoder_32.sv
// Sequential 32:5 encoder: serialises each set bit of a loaded vector as an index.
module pending_encoder_32
  import pending_enc_pkg::*;
#(
  parameter int WIDTH     = PENC_WIDTH,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic             drain, single, xfer, load_acc;
  logic [WIDTH-1:0] clr_mask;

  prio_enc_comb #(
    .WIDTH    (WIDTH),
    .LSB_FIRST(LSB_FIRST),
    .IDX_W    (IDX_W)
  ) u_enc (
    .vec(pending_q),
    .idx(enc_idx),
    .any(enc_any)
  );

  assign drain    = (state_q == DRAIN);
  assign single   = ((pending_q & (pending_q - WIDTH'(1))) == '0);
  assign xfer     = out_valid && out_ready;
  assign load_acc = load_valid && load_ready;
  assign clr_mask = WIDTH'(1) << enc_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Flush dominates; a load can only land in DRAIN on the last transfer, so it
  // simply replaces whatever the transfer would have left behind.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (flush) begin
      state_d   = IDLE;
      pending_d = '0;
    end else if (load_acc && (load_vec != '0)) begin
      state_d   = DRAIN;
      pending_d = load_vec;
    end else if (xfer) begin
      pending_d = pending_q & ~clr_mask;
      if (out_last) state_d = IDLE;
    end
  end

  always_comb begin
    out_valid  = drain;
    busy       = drain;
    out_idx    = drain ? enc_idx : '0;
    out_last   = drain && single;
    load_ready = !reset || (!flush && (!drain || (out_ready && single)));
  end

  // enc_any is only meaningful as a consistency check: DRAIN always holds bits.
  logic unused_any;
  assign unused_any = enc_any;
endmodule

// File: tb/tb_pending_encoder_32.sv
// Directed bench for pending_encoder_32 (LSB-first and MSB-first instances).
module tb_pending_encoder_32;
  logic        clk = 1'b0;
  logic        reset;
  logic        flush, load_valid, out_ready;
  logic [31:0] load_vec;
  logic        load_ready, out_valid, out_last, busy;
  logic [4:0]  out_idx;
  logic        m_load_valid, m_out_ready;
  logic [31:0] m_load_vec;
  logic        m_load_ready, m_out_valid, m_out_last, m_busy;
  logic [4:0]  m_out_idx;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pending_encoder_32 #(.LSB_FIRST(1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .load_valid(load_valid), .load_ready(load_ready), .load_vec(load_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .busy(busy)
  );

  pending_encoder_32 #(.LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .flush(1'b0),
    .load_valid(m_load_valid), .load_ready(m_load_ready), .load_vec(m_load_vec),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_idx(m_out_idx),
    .out_last(m_out_last), .busy(m_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] i, input logic l);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".idx"},   32'(out_idx),   32'(i));
    chk({tag, ".last"},  32'(out_last),  32'(l));
  endtask

  task automatic chk_msb(input string tag, input logic v, input logic [4:0] i, input logic l);
    chk({tag, ".valid"}, 32'(m_out_valid), 32'(v));
    chk({tag, ".idx"},   32'(m_out_idx),   32'(i));
    chk({tag, ".last"},  32'(m_out_last),  32'(l));
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; load_valid = 1'b0; out_ready = 1'b0; load_vec = '0;
    m_load_valid = 1'b0; m_out_ready = 1'b0; m_load_vec = '0;

    // 1. reset state, then release with no load
    #12;
    chk_out("rst", 1'b0, 5'd0, 1'b0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.load_ready", 32'(load_ready), 32'd1);
    @(negedge clk); reset = 1'b1;
    cyc(); cyc();
    chk_out("idle", 1'b0, 5'd0, 1'b0);
    chk("idle.busy", 32'(busy), 32'd0);
    chk("idle.load_ready", 32'(load_ready), 32'd1);

    // 2. multi-bit drain 0x8000_0025 -> 0,2,5,31
    load_valid = 1'b1; load_vec = 32'h8000_0025; out_ready = 1'b1;
    cyc(); load_valid = 1'b0;
    chk_out("drain0", 1'b1, 5'd0, 1'b0);
    chk("drain0.busy", 32'(busy), 32'd1);
    chk("drain0.load_ready", 32'(load_ready), 32'd0);
    cyc(); chk_out("drain2", 1'b1, 5'd2, 1'b0);
    cyc(); chk_out("drain5", 1'b1, 5'd5, 1'b0);
    cyc(); chk_out("drain31", 1'b1, 5'd31, 1'b1);
    cyc(); chk_out("drain_end", 1'b0, 5'd0, 1'b0);
    chk("drain_end.busy", 32'(busy), 32'd0);

    // 3. backpressure on 0x300
    out_ready = 1'b0; load_valid = 1'b1; load_vec = 32'h0000_0300;
    cyc(); load_valid = 1'b0;
    chk_out("bp0", 1'b1, 5'd8, 1'b0);
    cyc(); chk_out("bp1", 1'b1, 5'd8, 1'b0);
    cyc(); chk_out("bp2", 1'b1, 5'd8, 1'b0);
    out_ready = 1'b1;
    chk_out("bp8", 1'b1, 5'd8, 1'b0);
    cyc(); chk_out("bp9", 1'b1, 5'd9, 1'b1);
    cyc(); chk_out("bp_end", 1'b0, 5'd0, 1'b0);

    // 4. back-to-back reload during the last transfer
    load_valid = 1'b1; load_vec = 32'h1;
    cyc();
    chk_out("b2b_a", 1'b1, 5'd0, 1'b1);
    load_vec = 32'h4;
    chk("b2b.load_ready", 32'(load_ready), 32'd1);
    cyc(); load_valid = 1'b0;
    chk_out("b2b_b", 1'b1, 5'd2, 1'b1);
    chk("b2b.busy", 32'(busy), 32'd1);
    cyc(); chk_out("b2b_end", 1'b0, 5'd0, 1'b0);

    // 5. flush beats a same-cycle load; zero load is dropped
    load_valid = 1'b1; load_vec = 32'hFFFF_FFFF;
    cyc(); load_valid = 1'b0;
    chk_out("fl_a", 1'b1, 5'd0, 1'b0);
    cyc(); chk_out("fl_b", 1'b1, 5'd1, 1'b0);
    flush = 1'b1; load_valid = 1'b1; load_vec = 32'h10;
    chk("fl.load_ready", 32'(load_ready), 32'd0);
    cyc(); flush = 1'b0; load_valid = 1'b0;
    chk_out("fl_c", 1'b0, 5'd0, 1'b0);
    chk("fl.busy", 32'(busy), 32'd0);
    cyc(); chk_out("fl_d", 1'b0, 5'd0, 1'b0);
    load_valid = 1'b1; load_vec = 32'h0;
    chk("zero.load_ready", 32'(load_ready), 32'd1);
    cyc(); load_valid = 1'b0;
    chk_out("zero_a", 1'b0, 5'd0, 1'b0);
    cyc(); chk_out("zero_b", 1'b0, 5'd0, 1'b0);

    // 6. MSB-first instance, then async reset mid-drain
    m_load_valid = 1'b1; m_load_vec = 32'h8000_0025; m_out_ready = 1'b1;
    cyc(); m_load_valid = 1'b0;
    chk_msb("msb31", 1'b1, 5'd31, 1'b0);
    cyc(); chk_msb("msb5", 1'b1, 5'd5, 1'b0);
    cyc(); chk_msb("msb2", 1'b1, 5'd2, 1'b0);
    cyc(); chk_msb("msb0", 1'b1, 5'd0, 1'b1);
    cyc(); chk_msb("msb_end", 1'b0, 5'd0, 1'b0);

    m_load_valid = 1'b1; m_load_vec = 32'h0000_00F0;
    load_valid = 1'b1; load_vec = 32'h0000_0F00;
    cyc(); m_load_valid = 1'b0; load_valid = 1'b0;
    chk_msb("ar_m0", 1'b1, 5'd7, 1'b0);
    chk_out("ar_l0", 1'b1, 5'd8, 1'b0);
    cyc();
    chk_msb("ar_m1", 1'b1, 5'd6, 1'b0);
    chk_out("ar_l1", 1'b1, 5'd9, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk_msb("ar_m", 1'b0, 5'd0, 1'b0);
    chk("ar_m.busy", 32'(m_busy), 32'd0);
    chk("ar_m.load_ready", 32'(m_load_ready), 32'd1);
    chk_out("ar_l", 1'b0, 5'd0, 1'b0);
    chk("ar_l.busy", 32'(busy), 32'd0);
    chk("ar_l.load_ready", 32'(load_ready), 32'd1);
    cyc();
    reset = 1'b1;
    cyc();
    chk_out("post_rst", 1'b0, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
